// File: rtl/fp_align_add_pkg.sv
// Shared configuration for the floating-point align-and-add stage.
// EXP_SIZE / MANTIS_SIZE macros set the default operand widths.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

package fp_align_add_pkg;

  localparam int EXP_SIZE_DEFAULT    = `EXP_SIZE;
  localparam int MANTIS_SIZE_DEFAULT = `MANTIS_SIZE;

  // Past this many shifts the small operand has left the guard position entirely.
  localparam int MAX_SHIFT = MANTIS_SIZE_DEFAULT + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] ADD   = 2'd2;

  function automatic int cnt_width(input int mantis_size);
    return $clog2(mantis_size + 3);
  endfunction

endpackage

// File: rtl/fp_align_add_align_shifter.sv
// Alignment shifter for the small operand: shift register, sticky and shift count.
// BARREL_ALIGN_EN selects a single-cycle barrel shift instead of one bit per clock.
module align_shifter
  import fp_align_add_pkg::*;
#(
  parameter int MANTIS_SIZE = MANTIS_SIZE_DEFAULT,
  parameter int CW          = cnt_width(MANTIS_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [MANTIS_SIZE-1:0] frac_in,
  input  logic [CW-1:0]          shift_in,
  input  logic                   step,
  output logic [MANTIS_SIZE+1:0] shifted,
  output logic                   sticky,
  output logic                   last
);

  localparam int W = MANTIS_SIZE + 2;

  logic [W-1:0]  sreg;
  logic          sticky_r;
  logic [CW-1:0] cnt;

`ifdef BARREL_ALIGN_EN
  logic [2*W-1:0] wide;

  // Lower half of the widened shift holds every bit that fell past guard.
  always_comb begin
    wide = {sreg, {W{1'b0}}} >> cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      sticky_r <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      sreg     <= {1'b1, frac_in, 1'b0};
      sticky_r <= 1'b0;
      cnt      <= shift_in;
    end else if (step) begin
      sreg     <= wide[2*W-1:W];
      sticky_r <= sticky_r | (|wide[W-1:0]);
      cnt      <= '0;
    end
  end

  assign last = 1'b1;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      sticky_r <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      sreg     <= {1'b1, frac_in, 1'b0};
      sticky_r <= 1'b0;
      cnt      <= shift_in;
    end else if (step && (cnt != '0)) begin
      sreg     <= sreg >> 1;
      sticky_r <= sticky_r | sreg[0];
      cnt      <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);
`endif

  assign shifted = sreg;
  assign sticky  = sticky_r;

endmodule

// File: rtl/fp_align_add.sv
// Floating-point align-and-add stage feeding the normalize/round pair.
// Alignment is iterative unless BARREL_ALIGN_EN is defined (see align_shifter).
module fp_align_add
  import fp_align_add_pkg::*;
#(
  parameter int EXP_SIZE    = EXP_SIZE_DEFAULT,
  parameter int MANTIS_SIZE = MANTIS_SIZE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_in,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [EXP_SIZE-1:0]    exp_a,
  input  logic [EXP_SIZE-1:0]    exp_b,
  input  logic [MANTIS_SIZE-1:0] mantis_a,
  input  logic [MANTIS_SIZE-1:0] mantis_b,
  output logic                   busy,
  output logic                   done,
  output logic                   sign_out,
  output logic [EXP_SIZE-1:0]    exp_out,
  output logic [MANTIS_SIZE+2:0] mantis_out,
  output logic                   loss,
  output logic                   operator_out
);

  localparam int CW        = cnt_width(MANTIS_SIZE);
  localparam int SHIFT_CAP = MAX_SHIFT - MANTIS_SIZE_DEFAULT + MANTIS_SIZE;

  logic [1:0]             state;
  logic [EXP_SIZE-1:0]    exp_l;
  logic [MANTIS_SIZE-1:0] frac_l;
  logic                   sign_r;
  logic                   eff_op;

  logic                   a_larger;
  logic [EXP_SIZE-1:0]    exp_diff;
  logic [CW-1:0]          shift_amt;
  logic                   accept;

  logic [MANTIS_SIZE+1:0] s_shifted;
  logic                   s_sticky;
  logic                   align_last;

  logic [MANTIS_SIZE+2:0] l_ext;
  logic [MANTIS_SIZE+2:0] s_ext;
  logic [MANTIS_SIZE+2:0] result;

  // On a full tie A is treated as the larger operand.
  always_comb begin
    a_larger  = (exp_a > exp_b) || ((exp_a == exp_b) && (mantis_a >= mantis_b));
    exp_diff  = a_larger ? (exp_a - exp_b) : (exp_b - exp_a);
    shift_amt = (int'(exp_diff) > SHIFT_CAP) ? CW'(SHIFT_CAP) : CW'(exp_diff);
    accept    = (state == IDLE) && start;
  end

  align_shifter #(
    .MANTIS_SIZE (MANTIS_SIZE),
    .CW          (CW)
  ) u_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .frac_in  (a_larger ? mantis_b : mantis_a),
    .shift_in (shift_amt),
    .step     (state == ALIGN),
    .shifted  (s_shifted),
    .sticky   (s_sticky),
    .last     (align_last)
  );

  // L >= S by construction, so the subtraction never goes negative.
  always_comb begin
    l_ext  = {2'b01, frac_l, 1'b0};
    s_ext  = {1'b0, s_shifted};
    result = eff_op ? (l_ext - s_ext) : (l_ext + s_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      exp_l        <= '0;
      frac_l       <= '0;
      sign_r       <= 1'b0;
      eff_op       <= 1'b0;
      sign_out     <= 1'b0;
      exp_out      <= '0;
      mantis_out   <= '0;
      loss         <= 1'b0;
      operator_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_l  <= a_larger ? exp_a : exp_b;
            frac_l <= a_larger ? mantis_a : mantis_b;
            eff_op <= op_in ^ sign_a ^ sign_b;
            if (op_in)
              sign_r <= a_larger ? sign_a : ~sign_b;
            else
              sign_r <= a_larger ? sign_a : sign_b;
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (align_last)
            state <= ADD;
        end
        ADD: begin
          mantis_out   <= result;
          exp_out      <= exp_l;
          loss         <= s_sticky;
          operator_out <= eff_op;
          sign_out     <= (result == '0) ? 1'b0 : sign_r;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Iterative floating-point align-and-add stage that sits directly upstream of the standardizer.
- Accepts two unpacked operands (sign, biased exponent, fraction with implicit hidden 1) plus an add/sub operation.
- Aligns the smaller operand by right-shifting one bit per clock, collecting guard and sticky bits, then adds or subtracts the magnitudes.
- Outputs exp, unnormalized mantissa (MANTIS_SIZE+3 bits), loss and effective operator, in the exact form the normalize/round pair consumes.

Parameters:
- EXP_SIZE, `EXP_SIZE (8), exponent width.
- MANTIS_SIZE, `MANTIS_SIZE (23), stored fraction width, hidden bit excluded.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only while busy=0.
- op_in  in  1  0=add, 1=sub.
- sign_a, sign_b  in  1 each  operand signs.
- exp_a, exp_b  in  EXP_SIZE each  biased exponents.
- mantis_a, mantis_b  in  MANTIS_SIZE each  fractions.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result outputs valid from this cycle.
- sign_out  out  1  result sign.
- exp_out  out  EXP_SIZE  exponent of larger operand.
- mantis_out  out  MANTIS_SIZE+3  {carry, hidden, fraction[MANTIS_SIZE-1:0], guard}.
- loss  out  1  sticky: OR of all bits shifted past guard.
- operator_out  out  1  effective operation, op_in^sign_a^sign_b.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs and internal registers are 0.
  - State is IDLE.
  - Asserting rst_n mid-operation aborts the operation; no done is produced.
- FSM IDLE -> ALIGN -> ADD -> IDLE.
- IDLE: on start=1, capture operands.
  - Larger magnitude is L: compare exponent first, then fraction. On a full tie, A is L.
  - Small operand S is held as {1,fraction,guard=0}, sticky=0.
  - Shift count: cnt = min(exp_L - exp_S, MANTIS_SIZE+2).
  - Register effective op and sign_out:
    - add: sign_out = sign_L.
    - sub: sign_out = L is A ? sign_a : ~sign_b.
  - Go to ALIGN; busy=1.
- ALIGN, cnt>0: shift S right by 1 (bit falling out of guard ORs into sticky); cnt--.
- ALIGN, cnt==0: go to ADD. cnt=0 on entry spends exactly one cycle in ALIGN.
- Capped shift (difference > MANTIS_SIZE+2): after the cap, S is all zero and sticky=1.
- ADD: register the result, pulse done, clear busy, return to IDLE.
  - mantis_out = {0,1,frac_L,0} ± {0,S}, computed at MANTIS_SIZE+3 bits; never negative because L>=S.
  - exp_out = exp_L; loss = sticky; operator_out = effective op.
  - Exact cancellation (sub, equal magnitude): mantis_out=0, sign_out=0.
- Latency: start-accept edge to done = cnt+2 cycles (min 2, max MANTIS_SIZE+4).
- Results hold until the next done.
- start while busy=1 is ignored (no queuing).
- start may be asserted in the same cycle done pulses only if busy=0 at that edge, i.e. never. Back-to-back issue is possible from the cycle after done.
- Exponent arithmetic: unsigned EXP_SIZE subtraction of larger minus smaller, so no wrap. No special-case handling (zero/inf/NaN) in this block.

Optional Feature:
- BARREL_ALIGN_EN defined:
  - ALIGN performs the full cnt shift in one cycle with a barrel shifter; sticky = OR of all discarded bits.
  - Latency is fixed at 2 cycles for every difference.
- Undefined: the iterative one-bit-per-cycle shifter described above.
- Results are bit-identical in both modes.

Decomposition:
- Shared package/configuration header holds:
  - EXP_SIZE/MANTIS_SIZE defaults.
  - FSM state encoding (IDLE=2'd0, ALIGN=2'd1, ADD=2'd2).
  - Localparam MAX_SHIFT = MANTIS_SIZE+2.
- One natural sub-module: align_shifter, which holds the shift register, sticky accumulation and cnt. Its internals are swapped by BARREL_ALIGN_EN.
- Top level keeps the FSM, compare/swap and adder.

Test Plan:
- 1.0+1.0 (exp 127/127, frac 0, op 0) -> done at +2, exp_out 127, mantis_out={1,0,23'b0,0}, loss 0, sign_out 0.
- 1.0+2^-30 (exp 127/97) -> cnt capped 25, done at +27, mantis_out={0,1,23'b0,0}, loss 1. With BARREL_ALIGN_EN: same values, done at +2.
- 1.5-1.25 (exp 127/127, frac 0x400000/0x200000, op 1) -> exp_out 127, mantis_out={0,0,23'h200000,0}, operator_out 1, sign_out 0.
- 1.25-1.5 -> same magnitude as above, sign_out 1.
- 1.5-1.5 -> mantis_out 0, sign_out 0.
- 1.0+0.5 (exp 127/126) -> one shift, done at +3, mantis_out={0,1,23'h400000,0}.
- Second start pulsed while busy -> ignored, first result unchanged.
- rst_n low during ALIGN -> busy/done/outputs 0 immediately; no done after release.
